reset_sequencer: RTL and testbench

- Central reset controller for the system. It synchronises the board reset and waits for the clock source lock.
- It then releases NUM_DOM downstream domain resets one at a time, with a programmable gap between releases.
- It also handles a four-phase soft-reset handshake from software or a debug master.
- Sits at top level between the pad reset and every sys_rst_n consumer.

---
 rtl/rst_seq_pkg.sv | 29 ++
 rtl/sync_chain.sv | 31 +++
 rtl/reset_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_reset_sequencer.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rst_seq_pkg.sv
// Shared definitions for the reset sequencer: state encoding and the
// domain-index width helper.
package rst_seq_pkg;

  // State encoding, kept as plain constants so legacy code can compare
  // against them directly.
  localparam logic [2:0] S_RST         = 3'd0;
  localparam logic [2:0] S_WAIT_LOCK   = 3'd1;
  localparam logic [2:0] S_HOLD        = 3'd2;
  localparam logic [2:0] S_DONE        = 3'd3;
  localparam logic [2:0] S_SOFT_ASSERT = 3'd4;
  localparam logic [2:0] S_SOFT_WAIT   = 3'd5;

  // Named view of the same encoding, for casting the state in waveforms.
  typedef enum logic [2:0] {
    ST_RST         = S_RST,
    ST_WAIT_LOCK   = S_WAIT_LOCK,
    ST_HOLD        = S_HOLD,
    ST_DONE        = S_DONE,
    ST_SOFT_ASSERT = S_SOFT_ASSERT,
    ST_SOFT_WAIT   = S_SOFT_WAIT
  } state_e;

  // Width of a counter that indexes n domains; never narrower than 1 bit.
  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sync_chain.sv
// Single-bit multi-flop synchroniser with asynchronous clear.
// Used both as the reset synchroniser (d_i tied high) and as the lock
// data synchroniser.
module sync_chain
  import rst_seq_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  // Shift the input through STAGES flops; clear the whole chain on rst_n.
  // NOTE: the reset is asynchronous so the chain output drops the moment
  // rst_n falls, without waiting for a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      // NOTE: non-blocking so every stage samples its predecessor's old value.
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Central reset controller: synchronises the board reset and the clock
// lock, releases NUM_DOM domain resets one at a time HOLD_CYC cycles apart,
// and runs a four-phase soft-reset handshake.
// Optional build macro RST_SEQ_TIMEOUT_EN adds a sticky lock-wait timeout
// flag; without it timeout_o is tied low.
module reset_sequencer
  import rst_seq_pkg::*;
#(
  parameter int NUM_DOM     = 3,
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYC    = 16,
  parameter int CNT_W       = 8,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               lock_i,
  input  logic               soft_rst_req_i,
  output logic               soft_rst_ack_o,
  output logic [NUM_DOM-1:0] dom_rst_n_o,
  output logic               seq_done_o,
  output logic               busy_o,
  output logic               timeout_o
);

  localparam int                IDX_W     = idx_width(NUM_DOM);
  localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(HOLD_CYC - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DOM - 1);

  logic               rst_sync_n;
  logic               lock_s;

  logic [2:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [NUM_DOM-1:0] dom_q, dom_d;
  logic               done_q, done_d;
  logic               ack_q, ack_d;

  sync_chain #(.STAGES(SYNC_STAGES)) u_rst_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (1'b1),
    .q_o   (rst_sync_n)
  );

  sync_chain #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (lock_i),
    .q_o   (lock_s)
  );

  // Next-state logic: lock loss outranks everything once out of RST.
  always_comb begin
    // NOTE: every target gets a default first so no path infers a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    dom_d   = dom_q;
    done_d  = done_q;
    ack_d   = ack_q;

    if (state_q != S_RST && state_q != S_WAIT_LOCK && !lock_s) begin
      // Lost lock: pull every domain back into reset and wait to relock.
      state_d = S_WAIT_LOCK;
      cnt_d   = '0;
      idx_d   = '0;
      dom_d   = '0;
      done_d  = 1'b0;
      ack_d   = 1'b0;
    end else begin
      case (state_q)
        S_RST: begin
          if (rst_sync_n) state_d = S_WAIT_LOCK;
        end
        S_WAIT_LOCK: begin
          if (lock_s) begin
            state_d = S_HOLD;
            cnt_d   = '0;
            idx_d   = '0;
          end
        end
        S_HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            dom_d[idx_q] = 1'b1;
            cnt_d        = '0;
            idx_d        = idx_q + 1'b1;
            if (idx_q == IDX_LAST) begin
              done_d  = 1'b1;
              state_d = S_DONE;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_DONE: begin
          if (soft_rst_req_i) begin
            state_d = S_SOFT_ASSERT;
            cnt_d   = '0;
            dom_d   = '0;
            done_d  = 1'b0;
          end
        end
        S_SOFT_ASSERT: begin
          // Keep domains in reset for HOLD_CYC cycles before acknowledging.
          if (cnt_q == HOLD_LAST) begin
            ack_d   = 1'b1;
            cnt_d   = '0;
            state_d = S_SOFT_WAIT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_SOFT_WAIT: begin
          if (!soft_rst_req_i) begin
            ack_d   = 1'b0;
            state_d = S_HOLD;
            cnt_d   = '0;
            idx_d   = '0;
          end
        end
        default: state_d = S_RST;
      endcase
    end
  end

  // Sequencer registers, all cleared asynchronously by the board reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RST;
      cnt_q   <= '0;
      idx_q   <= '0;
      dom_q   <= '0;
      done_q  <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      dom_q   <= dom_d;
      done_q  <= done_d;
      ack_q   <= ack_d;
    end
  end

  assign dom_rst_n_o    = dom_q;
  assign seq_done_o     = done_q;
  assign soft_rst_ack_o = ack_q;
  assign busy_o         = (state_q != S_DONE);

`ifdef RST_SEQ_TIMEOUT_EN
  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             tmo_q, tmo_d;

  // Count cycles spent waiting for lock; the flag sticks until rst_n.
  always_comb begin
    tmo_cnt_d = '0;
    tmo_d     = tmo_q;
    if (state_q == S_WAIT_LOCK && state_d == S_WAIT_LOCK) begin
      tmo_cnt_d = (tmo_cnt_q == CNT_W'(TIMEOUT_CYC)) ? tmo_cnt_q : tmo_cnt_q + 1'b1;
      if (tmo_cnt_d == CNT_W'(TIMEOUT_CYC)) tmo_d = 1'b1;
    end
  end

  // Timeout counter and sticky flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q <= '0;
      tmo_q     <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      tmo_q     <= tmo_d;
    end
  end

  assign timeout_o = tmo_q;
`else
  // Timeout limit is meaningless without the counter; keep it referenced.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^CNT_W'(TIMEOUT_CYC);
  assign timeout_o          = 1'b0;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer. Expected outputs come from a
// timeline model: domain k is released once (k+1)*HOLD_CYC cycles have
// passed since the sequence started, plus fixed synchroniser latencies.
module tb_reset_sequencer;

  localparam int NUM_DOM     = 3;
  localparam int SYNC_STAGES = 2;
  localparam int HOLD_CYC    = 16;
  localparam int CNT_W       = 8;
  localparam int TIMEOUT_CYC = 255;
  localparam int SEQ_LEN     = NUM_DOM * HOLD_CYC;
`ifdef RST_SEQ_TIMEOUT_EN
  localparam logic TMO_EN = 1'b1;
`else
  localparam logic TMO_EN = 1'b0;
`endif

  typedef logic [NUM_DOM+3:0] vec_t;  // {dom, done, busy, ack, timeout}

  logic               clk = 1'b0;
  logic               rst_n;
  logic               lock_i;
  logic               soft_rst_req_i;
  logic               soft_rst_ack_o;
  logic [NUM_DOM-1:0] dom_rst_n_o;
  logic               seq_done_o;
  logic               busy_o;
  logic               timeout_o;

  int   checks   = 0;
  int   failures = 0;
  logic exp_tmo  = 1'b0;

  reset_sequencer #(
    .NUM_DOM     (NUM_DOM),
    .SYNC_STAGES (SYNC_STAGES),
    .HOLD_CYC    (HOLD_CYC),
    .CNT_W       (CNT_W),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .lock_i         (lock_i),
    .soft_rst_req_i (soft_rst_req_i),
    .soft_rst_ack_o (soft_rst_ack_o),
    .dom_rst_n_o    (dom_rst_n_o),
    .seq_done_o     (seq_done_o),
    .busy_o         (busy_o),
    .timeout_o      (timeout_o)
  );

  always #5 clk = ~clk;

  // Released-domain mask t cycles after the start of a release sequence.
  function automatic logic [NUM_DOM-1:0] exp_dom(input int t);
    logic [NUM_DOM-1:0] r;
    for (int k = 0; k < NUM_DOM; k++) r[k] = (t >= (k + 1) * HOLD_CYC);
    return r;
  endfunction

  function automatic vec_t obs();
    return {dom_rst_n_o, seq_done_o, busy_o, soft_rst_ack_o, timeout_o};
  endfunction

  // All domains held, nothing done, busy, no ack.
  function automatic vec_t idle_vec();
    return {{NUM_DOM{1'b0}}, 1'b0, 1'b1, 1'b0, exp_tmo};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Walk a release sequence from its first cycle (t=0) up to t_end,
  // optionally raising the soft request at t=req_at.
  task automatic run_seq(input string name, input int req_at, input int t_end);
    vec_t e;
    for (int t = 0; t <= t_end; t++) begin
      if (t == req_at) soft_rst_req_i = 1'b1;
      e = {exp_dom(t), logic'(t >= SEQ_LEN), logic'(t < SEQ_LEN), 1'b0, exp_tmo};
      checks++;
      if (obs() !== e) begin
        failures++;
        $display("FAIL %s t=%0d got=%b exp=%b", name, t, obs(), e);
      end
      if (t < t_end) tick(1);
    end
  endtask

  // Soft request is high and the sequencer sits in DONE: walk the assert
  // phase, the ack, the release of the request and the resequence.
  task automatic soft_finish(input string name);
    vec_t e;
    int   h;
    tick(1);
    checks++;
    if (obs() !== idle_vec()) begin
      failures++;
      $display("FAIL %s_enter got=%b exp=%b", name, obs(), idle_vec());
    end
    for (int j = 1; j <= HOLD_CYC; j++) begin
      tick(1);
      e = {{NUM_DOM{1'b0}}, 1'b0, 1'b1, logic'(j == HOLD_CYC), exp_tmo};
      checks++;
      if (obs() !== e) begin
        failures++;
        $display("FAIL %s_assert j=%0d got=%b exp=%b", name, j, obs(), e);
      end
    end
    h = $urandom_range(0, 5);
    for (int j = 0; j < h; j++) begin
      tick(1);
      e = {{NUM_DOM{1'b0}}, 1'b0, 1'b1, 1'b1, exp_tmo};
      checks++;
      if (obs() !== e) begin
        failures++;
        $display("FAIL %s_ackhold j=%0d got=%b exp=%b", name, j, obs(), e);
      end
    end
    soft_rst_req_i = 1'b0;
    tick(1);
    run_seq({name, "_reseq"}, -1, SEQ_LEN);
  endtask

  // From DONE: drop lock, confirm the clear latency, relock and reach t=0.
  task automatic restart_via_lock(input string name);
    vec_t e;
    lock_i = 1'b0;
    for (int j = 1; j <= SYNC_STAGES + 1; j++) begin
      tick(1);
      e = (j <= SYNC_STAGES) ? {{NUM_DOM{1'b1}}, 1'b1, 1'b0, 1'b0, exp_tmo} : idle_vec();
      checks++;
      if (obs() !== e) begin
        failures++;
        $display("FAIL %s_drop j=%0d got=%b exp=%b", name, j, obs(), e);
      end
    end
    tick($urandom_range(0, 5));
    lock_i = 1'b1;
    tick(SYNC_STAGES + 1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    lock_i = 1'b1;
    soft_rst_req_i = 1'b0;
    tick(3);
    checks++;
    if (obs() !== idle_vec()) begin
      failures++;
      $display("FAIL reset_state got=%b exp=%b", obs(), idle_vec());
    end
    rst_n = 1'b1;
    for (int k = 1; k <= SYNC_STAGES + 1; k++) begin
      tick(1);
      checks++;
      if (obs() !== idle_vec()) begin
        failures++;
        $display("FAIL powerup_pre k=%0d got=%b exp=%b", k, obs(), idle_vec());
      end
    end
    tick(1);
    run_seq("powerup", -1, SEQ_LEN);
  endtask

  task automatic test_lock_loss();
    vec_t e;
    int   td;
    restart_via_lock("lock_done");
    run_seq("lock_reseq", -1, SEQ_LEN);
    for (int it = 0; it < 3; it++) begin
      restart_via_lock("lock_pre");
      td = (it == 0) ? 20 : int'($urandom_range(HOLD_CYC + 1, 2 * HOLD_CYC - SYNC_STAGES - 2));
      run_seq("lock_part", -1, td);
      lock_i = 1'b0;
      for (int j = 1; j <= SYNC_STAGES + 1; j++) begin
        tick(1);
        e = (j <= SYNC_STAGES) ? {exp_dom(td + j), 1'b0, 1'b1, 1'b0, exp_tmo} : idle_vec();
        checks++;
        if (obs() !== e) begin
          failures++;
          $display("FAIL lock_hold td=%0d j=%0d got=%b exp=%b", td, j, obs(), e);
        end
      end
      tick($urandom_range(0, 5));
      lock_i = 1'b1;
      tick(SYNC_STAGES + 1);
      run_seq("lock_relock", -1, SEQ_LEN);
    end
  endtask

  task automatic test_soft_reset();
    vec_t e;
    int   w;
    w = $urandom_range(0, 4);
    for (int j = 0; j < w; j++) begin
      tick(1);
      e = {{NUM_DOM{1'b1}}, 1'b1, 1'b0, 1'b0, exp_tmo};
      checks++;
      if (obs() !== e) begin
        failures++;
        $display("FAIL soft_idle j=%0d got=%b exp=%b", j, obs(), e);
      end
    end
    soft_rst_req_i = 1'b1;
    soft_finish("soft");
  endtask

  task automatic test_req_during_seq();
    restart_via_lock("early_pre");
    run_seq("early_seq", (soft_rst_req_i === 1'b0) ? 5 : -1, SEQ_LEN);
    soft_finish("early");
    restart_via_lock("early_pre2");
    run_seq("early_seq2", int'($urandom_range(1, SEQ_LEN - 1)), SEQ_LEN);
    soft_finish("early2");
  endtask

  task automatic test_async_reset();
    vec_t e;
    int   ta;
    restart_via_lock("async_pre");
    ta = 40;
    run_seq("async_part", -1, ta);
    #2;
    rst_n = 1'b0;
    #1;
    e = {{NUM_DOM{1'b0}}, 1'b0, 1'b1, 1'b0, 1'b0};
    checks++;
    if (obs() !== e) begin
      failures++;
      $display("FAIL async_reset got=%b exp=%b", obs(), e);
    end
    exp_tmo = 1'b0;
    @(negedge clk);
    tick(2);
    checks++;
    if (obs() !== e) begin
      failures++;
      $display("FAIL async_held got=%b exp=%b", obs(), e);
    end
    rst_n = 1'b1;
    tick(SYNC_STAGES + 2);
    run_seq("async_reseq", -1, SEQ_LEN);
  endtask

  task automatic test_timeout();
    vec_t e;
    int   x;
    rst_n  = 1'b0;
    lock_i = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(SYNC_STAGES + TIMEOUT_CYC);
    checks++;
    if (timeout_o !== 1'b0) begin
      failures++;
      $display("FAIL tmo_early got=%b exp=0", timeout_o);
    end
    tick(1);
    e = {{NUM_DOM{1'b0}}, 1'b0, 1'b1, 1'b0, TMO_EN};
    checks++;
    if (obs() !== e) begin
      failures++;
      $display("FAIL tmo_set got=%b exp=%b", obs(), e);
    end
    exp_tmo = TMO_EN;
    x = $urandom_range(1, 20);
    tick(x);
    checks++;
    if (obs() !== idle_vec()) begin
      failures++;
      $display("FAIL tmo_sticky got=%b exp=%b", obs(), idle_vec());
    end
    lock_i = 1'b1;
    tick(SYNC_STAGES + 1);
    run_seq("tmo_seq", -1, SEQ_LEN);
  endtask

  initial begin
    test_reset();
    test_lock_loss();
    test_soft_reset();
    test_req_during_seq();
    test_async_reset();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Guard against a stuck run.
  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
